// File: rtl/ps2_key_rx_if.sv
// Bundles the PS/2 pin pair and the decoded key-event outputs of ps2_key_rx.
// The master side (receiver) produces ps2_key/err/state; the slave side drives the pins.
interface ps2_key_rx_if;
    // No valid/ready: an event is signalled only by a change of ps2_key[10], and the
    // word then holds until the next event. The consumer cannot stall the keyboard,
    // so there is no back-pressure. err is a lone 1-cycle strobe.
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        err;
    logic [1:0]  state;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output err,
        output state
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  err,
        input  state
    );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deframes 11-bit frames
// and turns set-2 scan-code bytes (with E0/F0/E1 prefixes) into toggle-flagged key events.
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 8000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_key_rx_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_fclk, r_fclk_d;
    logic [3:0]    r_fcnt;
    logic [1:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_sr;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic          r_byte_valid;
    logic [7:0]    r_byte;
    logic          r_err;
    logic          r_ext, r_rel;
    logic [2:0]    r_skip;
    logic [10:0]   r_key;

    logic          w_fall;
    logic          w_stop_ok;
    logic          w_frame_err;
    logic          w_timeout;

    function automatic logic is_reply(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips only after FILTER_LEN back-to-back samples of the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fclk   <= 1'b1;
            r_fclk_d <= 1'b1;
            r_fcnt   <= 4'd0;
        end else begin
            r_fclk_d <= r_fclk;
            if (r_clk_s2 == r_fclk) begin
                r_fcnt <= 4'd0;
            end else if (r_fcnt == 4'(FILTER_LEN - 1)) begin
                r_fclk <= r_clk_s2;
                r_fcnt <= 4'd0;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end
    end

    assign w_fall      = r_fclk_d & ~r_fclk;
    assign w_stop_ok   = r_dat_s2 & (^{r_sr, r_parity});
    assign w_frame_err = w_fall && (r_state == S_STOP) && !w_stop_ok;
    // A fall in the same cycle keeps the frame alive.
    assign w_timeout   = (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT)) && !w_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if ((r_state == S_IDLE) || w_fall) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TW'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= 3'd0;
            r_sr         <= 8'd0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_err        <= w_frame_err | w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (w_fall && !r_dat_s2) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        r_sr <= {r_dat_s2, r_sr[7:1]};
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_fall) begin
                        r_parity <= r_dat_s2;
                        r_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                        if (w_stop_ok) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_sr;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_timeout) begin
                r_state <= S_IDLE;
            end
        end
    end

    // E1 arms a 7-byte skip so the rest of the Pause sequence is swallowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= 3'd0;
            r_key  <= 11'd0;
        end else if (w_frame_err) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= 3'd0;
        end else if (w_timeout) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_byte == 8'hE1) begin
                r_skip <= 3'd7;
            end else if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_rel <= 1'b1;
            end else if (!r_ext && !r_rel && is_reply(r_byte)) begin
                r_skip <= 3'd0;
            end else begin
                r_key <= {~r_key[10], ~r_rel, r_ext, r_byte};
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign bus.ps2_key = r_key;
    assign bus.err     = r_err;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: drives PS/2 frames and checks events against a byte-level model.
module tb_ps2_key_rx;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 200;
    localparam int HALF_BIT   = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ps2_key_rx_if bus ();

    ps2_key_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;

    logic [10:0] exp_q[$];
    logic [10:0] last_key = 11'd0;
    logic        last_err = 1'b0;

    bit          m_ext;
    bit          m_rel;
    int          m_skip;
    logic [10:0] m_key;

    logic [7:0] replies [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    // Scoreboard: every change of ps2_key must be the next queued model event.
    always @(negedge clk) begin
        if (reset) begin
            last_key = bus.ps2_key;
            last_err = 1'b0;
        end else begin
            if (bus.err === 1'b1) begin
                err_cnt++;
                n_checks++;
                if (last_err === 1'b1) begin
                    n_errors++;
                    $display("FAIL err_width: err high %0d cycles in a row, required 1", 2);
                end
            end
            if (bus.ps2_key !== last_key) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL key_event: unexpected ps2_key=%h, no event expected", bus.ps2_key);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    if (bus.ps2_key !== e) begin
                        n_errors++;
                        $display("FAIL key_event: ps2_key=%h, required %h", bus.ps2_key, e);
                    end
                end
                n_checks++;
                if (bus.err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL err_with_key: err=%b during key update, required 0", bus.err);
                end
            end
            last_key = bus.ps2_key;
            last_err = bus.err;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
        m_key  = 11'd0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_rep;
        is_rep = 1'b0;
        foreach (replies[i]) if (replies[i] == b) is_rep = 1'b1;
        if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!m_ext && !m_rel && is_rep) begin
            m_skip = 0;
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            exp_q.push_back(m_key);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.ps2_data = v;
        repeat (HALF_BIT) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF_BIT) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // kind: 0 good frame, 1 wrong parity, 2 stop bit 0. The model is updated before the
    // frame goes out so the scoreboard already holds the event when the DUT emits it.
    task automatic send_frame(input logic [7:0] b, input int kind, input int gap);
        logic [10:0] f;
        f = {(kind == 2) ? 1'b0 : 1'b1, (kind == 1) ? (^b) : ~(^b), b, 1'b0};
        if (kind == 0) begin
            model_byte(b);
        end else begin
            m_ext  = 1'b0;
            m_rel  = 1'b0;
            m_skip = 0;
        end
        for (int i = 0; i < 11; i++) drive_bit(f[i]);
        bus.ps2_data = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 11);
        case (r)
            0:       return 8'hE0;
            1:       return 8'hF0;
            2:       return replies[$urandom_range(0, 6)];
            3:       return 8'hE1;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.ps2_key !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_key: ps2_key=%h, required 000", bus.ps2_key);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_err: err=%b, required 0", bus.err);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd0 || bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: state=%0d err=%b, required 0 0", bus.state, bus.err);
        end
    endtask

    task automatic test_make();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h61C || err_cnt != e0) begin
            n_errors++;
            $display("FAIL make_1c: ps2_key=%h errs=%0d, required 61c 0", bus.ps2_key, err_cnt - e0);
        end
    endtask

    task automatic test_break();
        send_frame(8'hF0, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h61C) begin
            n_errors++;
            $display("FAIL break_prefix: ps2_key=%h, required 61c", bus.ps2_key);
        end
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h01C) begin
            n_errors++;
            $display("FAIL break_1c: ps2_key=%h, required 01c", bus.ps2_key);
        end
    endtask

    task automatic test_extended();
        int e0;
        e0 = err_cnt;
        send_frame(8'hE0, 0, 40);
        send_frame(8'h75, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h775) begin
            n_errors++;
            $display("FAIL ext_make: ps2_key=%h, required 775", bus.ps2_key);
        end
        send_frame(8'hE0, 0, 40);
        send_frame(8'hF0, 0, 40);
        send_frame(8'h75, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h175) begin
            n_errors++;
            $display("FAIL ext_break: ps2_key=%h, required 175", bus.ps2_key);
        end
        send_frame(8'hFA, 0, 40);
        send_frame(8'hAA, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h175 || err_cnt != e0) begin
            n_errors++;
            $display("FAIL replies: ps2_key=%h errs=%0d, required 175 0", bus.ps2_key, err_cnt - e0);
        end
    endtask

    task automatic test_frame_errors();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h175 || err_cnt != e0 + 1) begin
            n_errors++;
            $display("FAIL parity_err: ps2_key=%h errs=%0d, required 175 1", bus.ps2_key, err_cnt - e0);
        end
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h61C) begin
            n_errors++;
            $display("FAIL after_parity: ps2_key=%h, required 61c", bus.ps2_key);
        end
        send_frame(8'h1C, 2, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h61C || err_cnt != e0 + 2) begin
            n_errors++;
            $display("FAIL stop_err: ps2_key=%h errs=%0d, required 61c 2", bus.ps2_key, err_cnt - e0);
        end
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h21C) begin
            n_errors++;
            $display("FAIL after_stop: ps2_key=%h, required 21c", bus.ps2_key);
        end
    endtask

    task automatic test_timeout();
        int e0;
        int waited;
        logic [3:0] part;
        e0 = err_cnt;
        part = 4'b1001;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        bus.ps2_data = 1'b1;
        waited = 0;
        while (waited < 300 && err_cnt == e0) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (err_cnt != e0 + 1) begin
            n_errors++;
            $display("FAIL timeout_err: errs=%0d after %0d cycles, required 1", err_cnt - e0, waited);
        end
        n_checks++;
        if (waited < 150) begin
            n_errors++;
            $display("FAIL timeout_early: err after %0d idle cycles, required >= 150", waited);
        end
        m_ext = 1'b0;
        m_rel = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd0) begin
            n_errors++;
            $display("FAIL timeout_idle: state=%0d, required 0", bus.state);
        end
        send_frame(8'h29, 0, 40);
        n_checks++;
        if (bus.ps2_key !== {~11'h21C >> 10, 10'h229}) begin
            n_errors++;
            $display("FAIL after_timeout: ps2_key=%h, required 629", bus.ps2_key);
        end
        send_frame(8'hE0, 0, 40);
        send_frame(8'h33, 1, 40);
        send_frame(8'h75, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h275) begin
            n_errors++;
            $display("FAIL ext_cleared: ps2_key=%h, required 275", bus.ps2_key);
        end
    endtask

    task automatic test_glitch_pause();
        int e0;
        logic [10:0] k0;
        logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        e0 = err_cnt;
        k0 = bus.ps2_key;
        bus.ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (15) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd0 || err_cnt != e0) begin
            n_errors++;
            $display("FAIL glitch: state=%0d errs=%0d, required 0 0", bus.state, err_cnt - e0);
        end
        bus.ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        foreach (pause[i]) send_frame(pause[i], 0, 20);
        n_checks++;
        if (bus.ps2_key !== k0 || err_cnt != e0) begin
            n_errors++;
            $display("FAIL pause: ps2_key=%h errs=%0d, required %h 0", bus.ps2_key, err_cnt - e0, k0);
        end
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== {~k0[10], 10'h21C}) begin
            n_errors++;
            $display("FAIL after_pause: ps2_key=%h, required %h", bus.ps2_key, {~k0[10], 10'h21C});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) send_frame(pick_byte(), 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.ps2_key !== m_key || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL back_to_back: ps2_key=%h pending=%0d, required %h 0", bus.ps2_key, exp_q.size(), m_key);
        end
    endtask

    task automatic test_random();
        int e0;
        int exp_errs;
        int kind;
        e0 = err_cnt;
        exp_errs = 0;
        for (int i = 0; i < 30; i++) begin
            kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (kind != 0) exp_errs++;
            send_frame(pick_byte(), kind, $urandom_range(0, 40));
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.ps2_key !== m_key || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_key: ps2_key=%h pending=%0d, required %h 0", bus.ps2_key, exp_q.size(), m_key);
        end
        n_checks++;
        if (err_cnt - e0 != exp_errs) begin
            n_errors++;
            $display("FAIL random_err: errs=%0d, required %0d", err_cnt - e0, exp_errs);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ps2_key !== 11'd0 || bus.state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid: ps2_key=%h state=%0d, required 000 0", bus.ps2_key, bus.state);
        end
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 0, 40);
        n_checks++;
        if (bus.ps2_key !== 11'h61C) begin
            n_errors++;
            $display("FAIL after_reset_mid: ps2_key=%h, required 61c", bus.ps2_key);
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_frame_errors();
        test_timeout();
        test_glitch_pause();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_queue: %0d events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
